// File: rtl/mul_16bit_seq.sv
// Multi-cycle unsigned 16x16 multiplier that reuses one 8x8 multiplier.
// A byte pair is multiplied each cycle and the shifted partial products are accumulated.

module mul_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = a * b;
endmodule

module mul_16bit_seq #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_product,
  output logic        busy
);
  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // MUL0  | a_lo*b_lo, offset 0
  // MUL1  | a_hi*b_lo, offset 8
  // MUL2  | a_lo*b_hi, offset 8
  // MUL3  | a_hi*b_hi, offset 16, result loaded on exit
  // DONE  | result held until out_ready
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] pp;
  logic [31:0] pp_shifted;
  logic [31:0] acc_next;
  logic        zero_op;

  mul_8bit u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  always_comb begin
    mul_a      = 8'd0;
    mul_b      = 8'd0;
    pp_shifted = 32'd0;
    case (state)
      MUL0: begin
        mul_a      = a_q[7:0];
        mul_b      = b_q[7:0];
        pp_shifted = {16'd0, pp};
      end
      MUL1: begin
        mul_a      = a_q[15:8];
        mul_b      = b_q[7:0];
        pp_shifted = {8'd0, pp, 8'd0};
      end
      MUL2: begin
        mul_a      = a_q[7:0];
        mul_b      = b_q[15:8];
        pp_shifted = {8'd0, pp, 8'd0};
      end
      MUL3: begin
        mul_a      = a_q[15:8];
        mul_b      = b_q[15:8];
        pp_shifted = {pp, 16'd0};
      end
      default: ;
    endcase
  end

  // Max total is 0xFFFE0001, so the 32-bit sum never wraps.
  assign acc_next = acc + pp_shifted;
  assign zero_op  = (ZERO_SKIP != 0) && ((in_a == 16'd0) || (in_b == 16'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      acc         <= 32'd0;
      out_product <= 32'd0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            acc      <= 32'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (zero_op) begin
              out_product <= 32'd0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= MUL0;
            end
          end
        end
        MUL0: begin
          acc   <= acc_next;
          state <= MUL1;
        end
        MUL1: begin
          acc   <= acc_next;
          state <= MUL2;
        end
        MUL2: begin
          acc   <= acc_next;
          state <= MUL3;
        end
        MUL3: begin
          acc         <= acc_next;
          out_product <= acc_next;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
